// File: rtl/poly_note_player.sv
// Polyphonic square-wave note player: key edges allocate voices from a fixed
// note table. The voices are mixed into one registered unsigned speaker sample.
module poly_note_player #(
    parameter int unsigned NUM_NOTES  = 8,
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned FREQ_W     = 19,
    parameter int unsigned OUT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_NOTES-1:0]  note_n,
    input  logic [2:0]            layer,
    input  logic [1:0]            mode,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic [FREQ_W-1:0]     freq_out,
    output logic [OUT_W-1:0]      speaker
);

    typedef enum logic [1:0] {
        MODE_MUTE = 2'd0,
        MODE_MONO = 2'd1,
        MODE_POLY = 2'd2,
        MODE_OFF  = 2'd3
    } mode_e;

    localparam int unsigned       MID_I = 1 << (OUT_W - 1);
    localparam logic [OUT_W-1:0]  MID   = OUT_W'(MID_I);
    localparam logic [OUT_W-1:0]  AMP   = OUT_W'((MID_I - 1) / NUM_VOICES);
    localparam logic [FREQ_W-1:0] ONE   = FREQ_W'(1);

    function automatic logic [FREQ_W-1:0] f_reload(input logic [2:0] n, input logic [2:0] l);
        logic [16:0] base;
        case (n)
            3'd0:    base = 17'd95556;
            3'd1:    base = 17'd85132;
            3'd2:    base = 17'd75844;
            3'd3:    base = 17'd71586;
            3'd4:    base = 17'd63776;
            3'd5:    base = 17'd56818;
            3'd6:    base = 17'd50620;
            default: base = 17'd47778;
        endcase
        return FREQ_W'(base) >> l;
    endfunction

    logic [NUM_NOTES-1:0]  r_sync1, r_sync2, r_prev;
    logic [1:0]            r_mode_prev;
    logic [NUM_VOICES-1:0] r_active, r_phase;
    logic [2:0]            r_note [NUM_VOICES];
    logic [2:0]            r_vlay [NUM_VOICES];
    logic [FREQ_W-1:0]     r_cnt  [NUM_VOICES];
    logic [OUT_W-1:0]      r_speaker;

    logic [NUM_VOICES-1:0] w_act, w_phase;
    logic [2:0]            w_note [NUM_VOICES];
    logic [2:0]            w_vlay [NUM_VOICES];
    logic [FREQ_W-1:0]     w_cnt  [NUM_VOICES];
    logic [NUM_NOTES-1:0]  w_press, w_rel;
    logic                  w_mode_chg, w_done, w_any, w_fhit;
    logic [2:0]            w_top;
    mode_e                 w_mode;
    logic [FREQ_W-1:0]     w_freq;
    logic [OUT_W-1:0]      w_mix;

    assign w_press    = r_sync2 & ~r_prev;
    assign w_rel      = ~r_sync2 & r_prev;
    assign w_mode     = mode_e'(mode);
    assign w_mode_chg = (mode != r_mode_prev);

    // Oscillators advance first; mode/release/press handling then overrides.
    always_comb begin
        w_act   = r_active;
        w_phase = r_phase;
        w_note  = r_note;
        w_vlay  = r_vlay;
        w_cnt   = r_cnt;
        w_done  = 1'b0;
        w_any   = 1'b0;
        w_top   = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (r_active[v]) begin
                if (r_cnt[v] != '0) begin
                    w_cnt[v] = r_cnt[v] - ONE;
                end else begin
                    w_phase[v] = ~r_phase[v];
                    w_cnt[v]   = f_reload(r_note[v], layer) - ONE;
                    w_vlay[v]  = layer;
                end
            end
        end
        if (w_mode_chg) w_act = '0;
        case (w_mode)
            MODE_MONO: begin
                for (int unsigned v = 1; v < NUM_VOICES; v++) w_act[v] = 1'b0;
                for (int unsigned k = 0; k < NUM_NOTES; k++) begin
                    if (r_sync2[k]) begin
                        w_any = 1'b1;
                        w_top = 3'(k);
                    end
                end
                if (!w_any) begin
                    w_act[0] = 1'b0;
                end else if (w_mode_chg || !r_active[0] || r_note[0] != w_top) begin
                    w_act[0]   = 1'b1;
                    w_note[0]  = w_top;
                    w_phase[0] = 1'b0;
                    w_cnt[0]   = f_reload(w_top, layer) - ONE;
                    w_vlay[0]  = layer;
                end
            end
            MODE_POLY: begin
                for (int unsigned k = 0; k < NUM_NOTES; k++) begin
                    if (w_rel[k]) begin
                        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                            if (w_act[v] && r_note[v] == 3'(k)) w_act[v] = 1'b0;
                        end
                    end
                end
                for (int unsigned k = 0; k < NUM_NOTES; k++) begin
                    if (w_press[k]) begin
                        w_done = 1'b0;
                        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                            if (!w_done && !w_act[v]) begin
                                w_act[v]   = 1'b1;
                                w_note[v]  = 3'(k);
                                w_phase[v] = 1'b0;
                                w_cnt[v]   = f_reload(3'(k), layer) - ONE;
                                w_vlay[v]  = layer;
                                w_done     = 1'b1;
                            end
                        end
                    end
                end
            end
            default: w_act = '0;
        endcase
    end

    always_comb begin
        w_freq = '0;
        w_fhit = 1'b0;
        w_mix  = MID;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (r_active[v] && !w_fhit) begin
                w_freq = f_reload(r_note[v], r_vlay[v]);
                w_fhit = 1'b1;
            end
            if (r_active[v]) w_mix = r_phase[v] ? (w_mix + AMP) : (w_mix - AMP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_prev      <= '0;
            r_mode_prev <= '0;
            r_active    <= '0;
            r_phase     <= '0;
            r_speaker   <= MID;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                r_note[v] <= '0;
                r_vlay[v] <= '0;
                r_cnt[v]  <= '0;
            end
        end else begin
            r_sync1     <= ~note_n;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            r_mode_prev <= mode;
            r_active    <= w_act;
            r_phase     <= w_phase;
            r_note      <= w_note;
            r_vlay      <= w_vlay;
            r_cnt       <= w_cnt;
            r_speaker   <= w_mix;
        end
    end

    assign voice_active = r_active;
    assign freq_out     = w_freq;
    assign speaker      = r_speaker;

endmodule

// File: tb/tb_poly_note_player.sv
// Bench for poly_note_player: directed scenarios plus random key/mode/layer
// activity, checked every cycle against a time-stamped voice model.
module tb_poly_note_player;

    localparam int NN = 8;
    localparam int NV = 4;
    localparam int FW = 19;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NN-1:0] note_n;
    logic [2:0]    layer;
    logic [1:0]    mode;
    logic [NV-1:0] voice_active;
    logic [FW-1:0] freq_out;
    logic [OW-1:0] speaker;

    always #10 clk = ~clk;

    poly_note_player #(
        .NUM_NOTES (NN),
        .NUM_VOICES(NV),
        .FREQ_W    (FW),
        .OUT_W     (OW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .note_n      (note_n),
        .layer       (layer),
        .mode        (mode),
        .voice_active(voice_active),
        .freq_out    (freq_out),
        .speaker     (speaker)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: each voice remembers when its next phase toggle is due.
    int unsigned TAB [8] = '{95556, 85132, 75844, 71586, 63776, 56818, 50620, 47778};
    bit          m_act  [NV];
    int          m_note [NV];
    bit          m_ph   [NV];
    longint      m_next [NV];
    int unsigned m_R    [NV];
    bit [NN-1:0] h1, h2, h3;
    logic [1:0]  m_pmode;
    longint      cyc = 0;
    int          m_spk = 128;

    task automatic start_voice(input int v, input int k);
        m_act[v]  = 1'b1;
        m_note[v] = k;
        m_ph[v]   = 1'b0;
        m_R[v]    = TAB[k] >> layer;
        m_next[v] = cyc + longint'(m_R[v]);
    endtask

    task automatic model_step();
        int hi, lo, top;
        bit found, chg;
        bit [NN-1:0] pr, rl;
        hi = 0;
        lo = 0;
        for (int v = 0; v < NV; v++) if (m_act[v]) begin
            if (m_ph[v]) hi++; else lo++;
        end
        m_spk = 128 + 31 * (hi - lo);
        if (!rst_n) begin
            for (int v = 0; v < NV; v++) begin
                m_act[v] = 0; m_ph[v] = 0; m_R[v] = 0;
            end
            h1 = '0; h2 = '0; h3 = '0;
            m_pmode = 2'd0;
            m_spk = 128;
        end else begin
            pr = h2 & ~h3;
            rl = ~h2 & h3;
            chg = (mode != m_pmode);
            m_pmode = mode;
            for (int v = 0; v < NV; v++) begin
                if (m_act[v] && cyc == m_next[v]) begin
                    m_ph[v]   = ~m_ph[v];
                    m_R[v]    = TAB[m_note[v]] >> layer;
                    m_next[v] = cyc + longint'(m_R[v]);
                end
            end
            if (mode == 2'd1) begin
                for (int v = 1; v < NV; v++) m_act[v] = 0;
                top = -1;
                for (int k = 0; k < NN; k++) if (h2[k]) top = k;
                if (top < 0) m_act[0] = 0;
                else if (chg || !m_act[0] || m_note[0] != top) start_voice(0, top);
            end else if (mode == 2'd2) begin
                if (chg) for (int v = 0; v < NV; v++) m_act[v] = 0;
                for (int k = 0; k < NN; k++) if (rl[k])
                    for (int v = 0; v < NV; v++) if (m_act[v] && m_note[v] == k) m_act[v] = 0;
                for (int k = 0; k < NN; k++) if (pr[k]) begin
                    found = 0;
                    for (int v = 0; v < NV; v++) if (!found && !m_act[v]) begin
                        start_voice(v, k);
                        found = 1;
                    end
                end
            end else begin
                for (int v = 0; v < NV; v++) m_act[v] = 0;
            end
            h3 = h2;
            h2 = h1;
            h1 = ~note_n;
        end
        cyc++;
    endtask

    task automatic tick();
        logic [NV-1:0] ev;
        int unsigned   ef;
        bit            seen;
        @(posedge clk);
        model_step();
        #1;
        ev = '0;
        ef = 0;
        seen = 0;
        for (int v = 0; v < NV; v++) begin
            ev[v] = m_act[v];
            if (m_act[v] && !seen) begin
                ef = m_R[v];
                seen = 1;
            end
        end
        check_eq("model_voice_active", 32'(voice_active), 32'(ev));
        check_eq("model_freq_out", 32'(freq_out), ef);
        check_eq("model_speaker", 32'(speaker), 32'(m_spk));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n, idx;
        rst_n  = 1'b0;
        note_n = '0;
        mode   = 2'd2;
        layer  = 3'd0;
        ticks(4);
        check_eq("reset_speaker", 32'(speaker), 128);
        check_eq("reset_active", 32'(voice_active), 0);
        check_eq("reset_freq", 32'(freq_out), 0);

        note_n = '1;
        rst_n  = 1'b1;
        ticks(4);
        note_n[0] = 1'b0;
        ticks(2);
        check_eq("press_latency_early", 32'(voice_active), 0);
        tick();
        check_eq("press_active", 32'(voice_active), 32'h1);
        check_eq("press_freq", 32'(freq_out), 95556);
        tick();
        check_eq("press_speaker", 32'(speaker), 97);
        note_n[0] = 1'b1;
        ticks(3);
        check_eq("release_active", 32'(voice_active), 0);
        ticks(2);

        layer = 3'd2;
        note_n[7] = 1'b0;
        ticks(3);
        check_eq("layer_start_freq", 32'(freq_out), 11944);
        ticks(100);
        n = 100;
        layer = 3'd5;
        while (freq_out != 19'd1493 && n < 13000) begin
            tick();
            n++;
        end
        check_eq("layer_half_period", 32'(n), 11944);
        ticks(1493 * 2 + 5);
        check_eq("layer_new_freq", 32'(freq_out), 1493);

        layer  = 3'd7;
        note_n = '1;
        ticks(5);
        note_n = ~8'h1F;
        ticks(3);
        check_eq("overflow_active", 32'(voice_active), 32'hF);
        check_eq("overflow_freq", 32'(freq_out), 746);
        tick();
        check_eq("mix_all_low", 32'(speaker), 4);
        ticks(746);
        check_eq("mix_all_high", 32'(speaker), 252);
        note_n[1] = 1'b1;
        ticks(3);
        check_eq("overflow_free1", 32'(voice_active), 32'hD);
        note_n[4] = 1'b1;
        ticks(3);
        check_eq("dropped_release", 32'(voice_active), 32'hD);
        note_n[4] = 1'b0;
        ticks(3);
        check_eq("repress_active", 32'(voice_active), 32'hF);
        note_n[0] = 1'b1;
        ticks(3);
        check_eq("note4_in_voice1", 32'(freq_out), 498);
        note_n = '1;
        ticks(5);

        mode  = 2'd1;
        layer = 3'd0;
        ticks(2);
        note_n = ~8'h24;
        ticks(3);
        check_eq("mono_active", 32'(voice_active), 32'h1);
        check_eq("mono_high", 32'(freq_out), 56818);
        note_n = ~8'h04;
        ticks(3);
        check_eq("mono_fallback", 32'(freq_out), 75844);
        check_eq("mono_fallback_active", 32'(voice_active), 32'h1);
        tick();
        check_eq("mono_phase0", 32'(speaker), 97);
        note_n = '1;
        ticks(5);

        mode  = 2'd2;
        layer = 3'd7;
        ticks(2);
        note_n = ~8'h4A;
        ticks(3);
        check_eq("mute_pre_active", 32'(voice_active), 32'h7);
        mode = 2'd0;
        tick();
        check_eq("mute_active", 32'(voice_active), 0);
        tick();
        check_eq("mute_speaker", 32'(speaker), 128);
        mode = 2'd2;
        ticks(10);
        check_eq("held_not_realloc", 32'(voice_active), 0);
        note_n[3] = 1'b1;
        ticks(3);
        note_n[3] = 1'b0;
        ticks(3);
        check_eq("realloc_active", 32'(voice_active), 32'h1);
        check_eq("realloc_freq", 32'(freq_out), 559);

        for (int i = 0; i < 4000; i++) begin
            rst_n = 1'b1;
            if ($urandom_range(15, 0) == 0) begin
                idx = $urandom_range(NN - 1, 0);
                note_n[idx] = ~note_n[idx];
            end
            if ($urandom_range(199, 0) == 0) mode = 2'($urandom_range(3, 0));
            if ($urandom_range(99, 0) == 0) layer = 3'($urandom_range(7, 4));
            if ($urandom_range(499, 0) == 0) rst_n = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
